// File: rtl/beat_visualizer.sv
// Beat chaser for the music player: flashes an 8-LED pattern on each crotchet,
// decays the brightness with PWM dimming against low_count, and counts beat/bar.
module beat_visualizer #(
   parameter logic [6:0] SONG_START  = 7'd1,
   parameter logic [7:0] DECAY_STEP  = 8'd8,
   parameter logic [7:0] FLASH_LEVEL = 8'd255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] crotchet,
   input  logic       crotchet_pulse,
   input  logic [9:0] low_count,
   input  logic       enable,
   output logic [7:0] leds,
   output logic [1:0] beat,
   output logic [4:0] bar,
   output logic       sync_err,
   output logic       active
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FADE = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] brightness, bright_nxt;
   logic [6:0] prev_crotchet, prev_nxt;
   logic [1:0] beat_nxt;
   logic [4:0] bar_nxt;
   logic       err_nxt;
   logic [7:0] leds_nxt;
   logic [7:0] pattern;
   logic [7:0] decayed;
   logic [6:0] prev_inc;
   logic       decay_tick;
   logic       accept;

   assign decay_tick = (low_count == 10'd0);
   assign prev_inc   = prev_crotchet + 7'd1;
   assign decayed    = (brightness > DECAY_STEP) ? (brightness - DECAY_STEP) : 8'd0;

   // NOTE: every variable gets a default at the top of the block so no path
   // leaves one unassigned, which would infer a latch.
   always_comb begin
      state_nxt  = state;
      bright_nxt = brightness;
      prev_nxt   = prev_crotchet;
      beat_nxt   = beat;
      bar_nxt    = bar;
      err_nxt    = 1'b0;
      accept     = 1'b0;

      case (state)
         IDLE: begin
            if (crotchet_pulse && enable) begin
               state_nxt = RUN;
               accept    = 1'b1;
               beat_nxt  = 2'd0;
               bar_nxt   = 5'd0;
            end
         end
         RUN: begin
            if (!enable) begin
               state_nxt = FADE;
               if (decay_tick) bright_nxt = decayed;
            end else if (crotchet_pulse) begin
               accept = 1'b1;
               if (crotchet == SONG_START) begin
                  beat_nxt = 2'd0;
                  bar_nxt  = 5'd0;
               end else if (crotchet == prev_inc) begin
                  beat_nxt = beat + 2'd1;
                  if (beat == 2'd3) bar_nxt = bar + 5'd1;
               end else begin
                  beat_nxt = 2'd0;
                  err_nxt  = 1'b1;
               end
            end else if (decay_tick) begin
               bright_nxt = decayed;
            end
         end
         FADE: begin
            // Re-enable wins over the exit to IDLE; pulses here never flash.
            if (enable) state_nxt = RUN;
            else if (brightness == 8'd0) state_nxt = IDLE;
            if (decay_tick) bright_nxt = decayed;
         end
         default: state_nxt = IDLE;
      endcase

      if (accept) begin
         bright_nxt = FLASH_LEVEL;
         prev_nxt   = crotchet;
      end
   end

   // LEDs are computed from the post-edge brightness and counters so the
   // registered output lines up with them.
   always_comb begin
      pattern = (beat_nxt == 2'd0) ? 8'hFF : (8'd1 << {bar_nxt[0], beat_nxt});
      leds_nxt = 8'd0;
      if (state_nxt != IDLE && bright_nxt > low_count[9:2]) leds_nxt = pattern;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         brightness    <= 8'd0;
         prev_crotchet <= 7'd0;
         beat          <= 2'd0;
         bar           <= 5'd0;
         sync_err      <= 1'b0;
         leds          <= 8'd0;
         active        <= 1'b0;
      end else begin
         state         <= state_nxt;
         brightness    <= bright_nxt;
         prev_crotchet <= prev_nxt;
         beat          <= beat_nxt;
         bar           <= bar_nxt;
         sync_err      <= err_nxt;
         leds          <= leds_nxt;
         active        <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_beat_visualizer.sv
// Directed bench for beat_visualizer: flash, beat/bar counting, decay, sync
// errors, fade-out, flash/decay coincidence and reset in FADE.
module tb_beat_visualizer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] crotchet;
   logic       crotchet_pulse;
   logic [9:0] low_count;
   logic       enable;
   logic [7:0] leds;
   logic [1:0] beat;
   logic [4:0] bar;
   logic       sync_err;
   logic       active;

   int checks = 0;
   int errors = 0;

   beat_visualizer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .crotchet       (crotchet),
      .crotchet_pulse (crotchet_pulse),
      .low_count      (low_count),
      .enable         (enable),
      .leds           (leds),
      .beat           (beat),
      .bar            (bar),
      .sync_err       (sync_err),
      .active         (active)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and land 1 ns after it, away from the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [9:0] lc);
      low_count = lc;
      tick();
      low_count = 10'd5;
   endtask

   task automatic pulse(input logic [6:0] c, input logic [9:0] lc);
      crotchet       = c;
      crotchet_pulse = 1'b1;
      low_count      = lc;
      tick();
      crotchet_pulse = 1'b0;
      low_count      = 10'd5;
   endtask

   initial begin
      rst_n          = 1'b0;
      enable         = 1'b0;
      crotchet       = 7'd0;
      crotchet_pulse = 1'b0;
      low_count      = 10'd5;
      tick();
      tick();
      check("rst_leds", leds, 0);
      check("rst_beat", beat, 0);
      check("rst_bar", bar, 0);
      check("rst_sync_err", sync_err, 0);
      check("rst_active", active, 0);
      rst_n = 1'b1;

      // Start of song and sequential crotchets; lc=1016 lights only at 255.
      enable = 1'b1;
      pulse(7'd1, 10'd1016);
      check("start_active", active, 1);
      check("start_beat", beat, 0);
      check("start_bar", bar, 0);
      check("start_leds", leds, 8'hFF);
      check("start_sync_err", sync_err, 0);
      pulse(7'd2, 10'd1016);
      check("c2_beat", beat, 1);
      check("c2_leds", leds, 8'h02);
      pulse(7'd3, 10'd1016);
      check("c3_beat", beat, 2);
      check("c3_leds", leds, 8'h04);
      pulse(7'd4, 10'd1016);
      check("c4_beat", beat, 3);
      check("c4_leds", leds, 8'h08);
      pulse(7'd5, 10'd1016);
      check("c5_beat", beat, 0);
      check("c5_bar", bar, 1);
      check("c5_leds", leds, 8'hFF);
      pulse(7'd6, 10'd1016);
      check("c6_beat", beat, 1);
      check("c6_leds", leds, 8'h20);

      // 31 decay ticks: 255 - 31*8 = 7.
      for (int i = 0; i < 31; i++) idle(10'd0);
      check("decay31_lit", leds, 8'h20);
      idle(10'd28);
      check("decay31_dark_at_7", leds, 0);
      idle(10'd24);
      check("decay31_lit_at_6", leds, 8'h20);
      idle(10'd0);
      check("decay32_leds", leds, 0);
      check("decay32_active", active, 1);
      for (int i = 0; i < 256; i++) begin
         idle(10'(i * 4 + 1));
         check("dark_sweep", leds, 0);
      end

      // Out-of-sequence crotchets.
      pulse(7'd9, 10'd1016);
      check("c9_sync_err", sync_err, 1);
      check("c9_beat", beat, 0);
      check("c9_bar", bar, 1);
      check("c9_leds", leds, 8'hFF);
      idle(10'd5);
      check("c9_err_one_cycle", sync_err, 0);
      pulse(7'd10, 10'd1016);
      check("c10_beat", beat, 1);
      check("c10_bar", bar, 1);
      check("c10_sync_err", sync_err, 0);
      pulse(7'd1, 10'd1016);
      pulse(7'd2, 10'd1016);
      pulse(7'd7, 10'd1016);
      check("c7_sync_err", sync_err, 1);
      check("c7_beat", beat, 0);
      check("c7_bar", bar, 0);
      idle(10'd5);
      check("c7_err_cleared", sync_err, 0);
      pulse(7'd127, 10'd1016);
      check("c127_sync_err", sync_err, 1);
      pulse(7'd0, 10'd1016);
      check("wrap0_sync_err", sync_err, 0);
      check("wrap0_beat", beat, 1);
      pulse(7'd1, 10'd1016);
      check("resync_beat", beat, 0);
      check("resync_bar", bar, 0);
      check("resync_sync_err", sync_err, 0);

      // One decay to 247, then drop enable together with a pulse.
      idle(10'd0);
      check("pre_fade_leds", leds, 8'hFF);
      enable = 1'b0;
      pulse(7'd2, 10'd988);
      check("fade_pulse_ignored_leds", leds, 0);
      check("fade_pulse_ignored_beat", beat, 0);
      check("fade_active", active, 1);
      pulse(7'd2, 10'd988);
      check("fade_pulse2_leds", leds, 0);
      check("fade_pulse2_beat", beat, 0);
      idle(10'd984);
      check("fade_bright_247", leds, 8'hFF);
      enable = 1'b1;
      idle(10'd5);
      check("reenable_active", active, 1);
      pulse(7'd2, 10'd1016);
      check("reenable_beat", beat, 1);
      check("reenable_leds", leds, 8'h02);

      // Full fade-out to IDLE.
      enable = 1'b0;
      idle(10'd5);
      for (int i = 0; i < 32; i++) idle(10'd0);
      check("fade32_leds", leds, 0);
      idle(10'd5);
      check("fade_idle_active", active, 0);
      check("fade_idle_leds", leds, 0);
      pulse(7'd3, 10'd1016);
      check("idle_disabled_pulse_active", active, 0);
      check("idle_disabled_pulse_leds", leds, 0);

      // Pulse coinciding with decay_tick: flash wins.
      enable = 1'b1;
      pulse(7'd1, 10'd1016);
      idle(10'd0);
      pulse(7'd2, 10'd0);
      check("coincide_beat", beat, 1);
      idle(10'd1016);
      check("coincide_bright_255", leds, 8'h02);

      // Reset asserted in FADE.
      enable = 1'b0;
      idle(10'd5);
      check("prereset_active", active, 1);
      rst_n = 1'b0;
      idle(10'd5);
      check("midfade_rst_leds", leds, 0);
      check("midfade_rst_beat", beat, 0);
      check("midfade_rst_bar", bar, 0);
      check("midfade_rst_sync_err", sync_err, 0);
      check("midfade_rst_active", active, 0);
      rst_n = 1'b1;
      idle(10'd5);
      check("post_rst_active", active, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
